// File: rtl/data_mem_ctrl_if.sv
// Core-side data-memory bus: one access request from the datapath and
// the load data / stall indication returned to it.
interface data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sel;
    logic [31:0] rdata;
    logic        busy;

    // Core side: issues accesses, consumes load data and stall
    modport master (
        output req, we, addr, wdata, sel,
        input  rdata, busy
    );

    // Controller side: accepts accesses, returns load data and stall
    modport slave (
        input  req, we, addr, wdata, sel,
        output rdata, busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the single-cycle datapath. Routes each
// access to internal word RAM, an external req/ack bank guarded by a
// watchdog, or a memory-mapped I/O register, and stalls the core on
// multi-cycle accesses.
module data_mem_ctrl #(
    parameter int          DEPTH    = 256,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus,
    output logic           ext_req,
    output logic           ext_we,
    output logic [31:0]    ext_addr,
    output logic [31:0]    ext_wdata,
    input  logic [31:0]    ext_rdata,
    input  logic           ext_ack,
    input  logic [31:0]    io_in,
    output logic [31:0]    io_out,
    output logic           err
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_RD   = 2'd1,
        EXT_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [31:0]     mem_r [DEPTH];
    logic [AW-1:0]   word_idx_s;
    logic            unused_addr_s;

    logic [31:0]     rdata_r;
    logic [31:0]     io_meta_r;
    logic [31:0]     io_sync_r;
    logic [31:0]     io_out_r;
    logic            err_r;
    logic            ext_req_r;
    logic            ext_we_r;
    logic [31:0]     ext_addr_r;
    logic [31:0]     ext_wdata_r;
    logic [WW-1:0]   wdog_r;

    // Per-cycle action strobes decoded by the FSM
    logic            ram_we_s;
    logic            ram_cap_s;
    logic            ext_start_s;
    logic            ext_ok_s;
    logic            ext_to_s;
    logic            wdog_inc_s;
    logic            io_we_s;
    logic            inv_s;
    logic            busy_s;
    logic [31:0]     rdata_s;

    // Word index ignores byte offset and upper bits, so addresses wrap
    assign word_idx_s    = bus.addr[AW+1:2];
    assign unused_addr_s = ^{bus.addr[31:AW+2], bus.addr[1:0]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, action strobes, stall and load-data selection
    always_comb begin
        state_nxt_s = state_r;
        ram_we_s    = 1'b0;
        ram_cap_s   = 1'b0;
        ext_start_s = 1'b0;
        ext_ok_s    = 1'b0;
        ext_to_s    = 1'b0;
        wdog_inc_s  = 1'b0;
        io_we_s     = 1'b0;
        inv_s       = 1'b0;
        busy_s      = 1'b0;
        rdata_s     = 32'h0;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    case (bus.sel)
                        2'b00: begin
                            if (bus.we) begin
                                ram_we_s = 1'b1;
                            end else begin
                                busy_s      = 1'b1;
                                state_nxt_s = RAM_RD;
                            end
                        end
                        2'b01: begin
                            busy_s      = 1'b1;
                            ext_start_s = 1'b1;
                            state_nxt_s = EXT_WAIT;
                        end
                        2'b10: begin
                            if (bus.we) begin
                                io_we_s = 1'b1;
                            end else begin
                                rdata_s = io_sync_r;
                            end
                        end
                        default: begin
                            inv_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RAM_RD: begin
                busy_s      = 1'b1;
                ram_cap_s   = 1'b1;
                state_nxt_s = DONE;
            end
            EXT_WAIT: begin
                busy_s = 1'b1;
                // An ack on the expiry cycle still counts as success
                if (ext_ack) begin
                    ext_ok_s    = 1'b1;
                    state_nxt_s = DONE;
                end else if (wdog_r == WW'(TIMEOUT - 1)) begin
                    ext_to_s    = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    wdog_inc_s = 1'b1;
                end
            end
            DONE: begin
                rdata_s     = rdata_r;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Stall and load data are forced to their idle values while in reset
    assign bus.busy  = reset & busy_s;
    assign bus.rdata = {32{reset}} & rdata_s;

    // Word RAM write port; contents survive reset and no write lands during it
    always_ff @(posedge clk) begin
        if (ram_we_s && reset) begin
            mem_r[word_idx_s] <= bus.wdata;
        end
    end

    // Completed-access read word shown in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= 32'h0;
        end else if (ram_cap_s) begin
            rdata_r <= mem_r[word_idx_s];
        end else if (ext_ok_s && !ext_we_r) begin
            rdata_r <= ext_rdata;
        end else if (ext_to_s) begin
            rdata_r <= ERR_WORD;
        end
    end

    // External command registers, request flag and watchdog
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_req_r   <= 1'b0;
            ext_we_r    <= 1'b0;
            ext_addr_r  <= 32'h0;
            ext_wdata_r <= 32'h0;
            wdog_r      <= {WW{1'b0}};
        end else if (ext_start_s) begin
            ext_req_r   <= 1'b1;
            ext_we_r    <= bus.we;
            ext_addr_r  <= bus.addr;
            ext_wdata_r <= bus.wdata;
            wdog_r      <= {WW{1'b0}};
        end else if (ext_ok_s || ext_to_s) begin
            ext_req_r <= 1'b0;
        end else if (wdog_inc_s) begin
            wdog_r <= wdog_r + WW'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous I/O input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_meta_r <= 32'h0;
            io_sync_r <= 32'h0;
        end else begin
            io_meta_r <= io_in;
            io_sync_r <= io_meta_r;
        end
    end

    // I/O output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_out_r <= 32'h0;
        end else if (io_we_s) begin
            io_out_r <= bus.wdata;
        end
    end

    // Sticky error: invalid target select or external timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (inv_s || ext_to_s) begin
            err_r <= 1'b1;
        end
    end

    assign ext_req   = ext_req_r;
    assign ext_we    = ext_we_r;
    assign ext_addr  = ext_addr_r;
    assign ext_wdata = ext_wdata_r;
    assign io_out    = io_out_r;
    assign err       = err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed steps from the access
// rules followed by a randomized mix, checked against a transaction-level
// reference model (word-indexed memory map, sticky error, latched load data).
module tb_data_mem_ctrl;
    localparam int          DEPTH    = 256;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    logic [31:0] io_in;
    logic [31:0] io_out;
    logic        err;

    data_mem_ctrl_if bus_if ();

    data_mem_ctrl #(
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT),
        .ERR_WORD (ERR_WORD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack),
        .io_in     (io_in),
        .io_out    (io_out),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] model_mem [int];
    logic [31:0] m_rdata_q;
    logic [31:0] m_io_out;
    logic [31:0] m_io_sync;
    logic        m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] w;
        w = (a >> 2) % 32'(DEPTH);
        return int'(w);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.req = 1'b1; bus_if.sel = 2'b00; bus_if.we = 1'b1;
        bus_if.addr = a; bus_if.wdata = d;
        #1;
        check("ram_wr_busy", {31'h0, bus_if.busy}, 32'h0);
        tick();
        model_mem[word_of(a)] = d;
        bus_if.req = 1'b0;
    endtask

    task automatic ram_read(input logic [31:0] a);
        logic [31:0] exp;
        exp = model_mem[word_of(a)];
        bus_if.req = 1'b1; bus_if.sel = 2'b00; bus_if.we = 1'b0; bus_if.addr = a;
        #1;
        check("ram_rd_busy_idle", {31'h0, bus_if.busy}, 32'h1);
        tick();
        check("ram_rd_busy_rd", {31'h0, bus_if.busy}, 32'h1);
        check("ram_rd_rdata_rd", bus_if.rdata, 32'h0);
        tick();
        check("ram_rd_busy_done", {31'h0, bus_if.busy}, 32'h0);
        check("ram_rd_data", bus_if.rdata, exp);
        m_rdata_q = exp;
        bus_if.req = 1'b0;
        tick();
        check("ram_rd_after", bus_if.rdata, 32'h0);
    endtask

    // ack_at: EXT_WAIT cycle (1-based) in which ack is driven; beyond TIMEOUT means never
    task automatic ext_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input int ack_at, input logic [31:0] rv);
        int  hi;
        bit  done;
        bit  ok;
        hi = 0; done = 1'b0; ok = 1'b0;
        bus_if.req = 1'b1; bus_if.sel = 2'b01; bus_if.we = w;
        bus_if.addr = a; bus_if.wdata = d; ext_ack = 1'b0;
        #1;
        check("ext_busy_idle", {31'h0, bus_if.busy}, 32'h1);
        check("ext_req_idle", {31'h0, ext_req}, 32'h0);
        tick();
        for (int k = 1; k <= TIMEOUT && !done; k++) begin
            hi += int'(ext_req);
            check("ext_busy_wait", {31'h0, bus_if.busy}, 32'h1);
            if (k == 1) begin
                check("ext_addr", ext_addr, a);
                check("ext_we", {31'h0, ext_we}, {31'h0, w});
                check("ext_wdata", ext_wdata, d);
            end
            if (k == ack_at) begin
                ext_ack = 1'b1; ext_rdata = rv; ok = 1'b1; done = 1'b1;
            end else if (k == TIMEOUT) begin
                done = 1'b1;
            end
            tick();
            ext_ack = 1'b0; ext_rdata = $urandom;
        end
        if (ok) begin
            if (!w) m_rdata_q = rv;
        end else begin
            m_err = 1'b1;
            m_rdata_q = ERR_WORD;
        end
        check("ext_req_cycles", 32'(hi), ok ? 32'(ack_at) : 32'(TIMEOUT));
        check("ext_req_done", {31'h0, ext_req}, 32'h0);
        check("ext_busy_done", {31'h0, bus_if.busy}, 32'h0);
        check("ext_rdata_done", bus_if.rdata, m_rdata_q);
        check("ext_err", {31'h0, err}, {31'h0, m_err});
        bus_if.req = 1'b0;
        tick();
        check("ext_back_idle", bus_if.rdata, 32'h0);
    endtask

    task automatic io_write(input logic [31:0] d);
        bus_if.req = 1'b1; bus_if.sel = 2'b10; bus_if.we = 1'b1; bus_if.wdata = d;
        #1;
        check("io_wr_busy", {31'h0, bus_if.busy}, 32'h0);
        check("io_out_before", io_out, m_io_out);
        tick();
        m_io_out = d;
        check("io_out", io_out, m_io_out);
        bus_if.req = 1'b0;
    endtask

    task automatic io_set(input logic [31:0] v);
        bus_if.req = 1'b0;
        io_in = v;
        tick();
        tick();
        m_io_sync = v;
    endtask

    task automatic io_read();
        bus_if.req = 1'b1; bus_if.sel = 2'b10; bus_if.we = 1'b0;
        #1;
        check("io_rd_busy", {31'h0, bus_if.busy}, 32'h0);
        check("io_rd_data", bus_if.rdata, m_io_sync);
        tick();
        bus_if.req = 1'b0;
    endtask

    task automatic invalid(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus_if.req = 1'b1; bus_if.sel = 2'b11; bus_if.we = w;
        bus_if.addr = a; bus_if.wdata = d;
        #1;
        check("inv_busy", {31'h0, bus_if.busy}, 32'h0);
        check("inv_rdata", bus_if.rdata, 32'h0);
        tick();
        m_err = 1'b1;
        check("inv_err", {31'h0, err}, 32'h1);
        bus_if.req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'h0, bus_if.busy}, 32'h0);
        check({tag, "_rdata"}, bus_if.rdata, 32'h0);
        check({tag, "_ext_req"}, {31'h0, ext_req}, 32'h0);
        check({tag, "_ext_we"}, {31'h0, ext_we}, 32'h0);
        check({tag, "_ext_addr"}, ext_addr, 32'h0);
        check({tag, "_ext_wdata"}, ext_wdata, 32'h0);
        check({tag, "_io_out"}, io_out, 32'h0);
        check({tag, "_err"}, {31'h0, err}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        int          idx;

        reset = 1'b0;
        bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.sel = 2'b00;
        bus_if.addr = 32'h0; bus_if.wdata = 32'h0;
        ext_ack = 1'b0; ext_rdata = 32'h0; io_in = 32'h0;
        m_rdata_q = 32'h0; m_io_out = 32'h0; m_io_sync = 32'h0; m_err = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();

        // RAM write/read and address wrap
        ram_write(32'h0000_0010, 32'h1234_5678);
        ram_read(32'h0000_0010);
        ram_write(32'h0000_0400, 32'h0BAD_CAFE);
        ram_read(32'h0000_0000);

        // External read, ack in third wait cycle
        ext_access(1'b0, 32'h8000_0000, 32'h0, 3, 32'hCAFE_F00D);
        // Ack coincides with watchdog expiry: success
        ext_access(1'b0, 32'h8000_0040, 32'h0, TIMEOUT, 32'h1357_9BDF);

        // Ack outside EXT_WAIT is ignored
        ext_ack = 1'b1; ext_rdata = 32'hFFFF_0000;
        tick();
        check("stray_ack_ext_req", {31'h0, ext_req}, 32'h0);
        check("stray_ack_rdata", bus_if.rdata, 32'h0);
        check("stray_ack_err", {31'h0, err}, {31'h0, m_err});
        ext_ack = 1'b0;

        // External write with no ack: timeout
        ext_access(1'b1, 32'h8000_0100, 32'h5555_AAAA, TIMEOUT + 5, 32'h0);
        // External write acked on first wait cycle keeps previous read word
        ext_access(1'b1, 32'h8000_0104, 32'h0F0F_0F0F, 1, 32'h7777_7777);

        // I/O register and synchronised input
        io_write(32'h0000_00A5);
        io_set(32'h0000_003C);
        io_read();

        // Reset in the middle of an external access
        bus_if.req = 1'b1; bus_if.sel = 2'b01; bus_if.we = 1'b0;
        bus_if.addr = 32'h8000_0200; bus_if.wdata = 32'h1111_2222;
        tick();
        tick();
        check("mid_ext_req", {31'h0, ext_req}, 32'h1);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        m_err = 1'b0; m_io_out = 32'h0; m_rdata_q = 32'h0; m_io_sync = 32'h0;
        tick();
        check_reset_outputs("mid_rst_hold");
        bus_if.req = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        ram_read(32'h0000_0010);

        // Invalid select: no write, sticky error
        invalid(1'b1, 32'h0000_0010, 32'hFFFF_FFFF);
        tick();
        tick();
        check("err_sticky", {31'h0, err}, 32'h1);
        ram_read(32'h0000_0010);

        // Randomized mix
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            a[9:2] = 8'(i);
            ram_write(a, $urandom);
        end
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            a = $urandom;
            idx = int'($urandom_range(0, 15));
            a[9:2] = 8'(idx);
            case (op)
                0, 1:    ram_write(a, $urandom);
                2, 3:    ram_read(a);
                4, 5:    ext_access(1'($urandom), $urandom, $urandom,
                                    int'($urandom_range(1, TIMEOUT + 3)), $urandom);
                6:       io_write($urandom);
                7:       begin io_set($urandom); io_read(); end
                8:       invalid(1'($urandom), a, $urandom);
                default: begin
                    bus_if.req = 1'b0;
                    tick();
                    check("rand_idle_rdata", bus_if.rdata, 32'h0);
                    check("rand_idle_err", {31'h0, err}, {31'h0, m_err});
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller directly downstream of the single-cycle datapath. It consumes the datapath's ALU result as the address, its write data, and its 2-bit memory selector. It routes each access to one of three targets: internal word RAM, an external bank behind a req/ack handshake, or a memory-mapped I/O register. It returns read data for the result mux and drives `busy` so the core holds its PC on multi-cycle accesses.

## Interface
Parameters:
- `DEPTH`, 256: internal RAM words; power of two.
- `TIMEOUT`, 16: maximum cycles to wait for `ext_ack`; ≥2.
- `ERR_WORD`, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `req` in 1: access request from the core, held stable while `busy`.
- `we` in 1: 1 = write, 0 = read.
- `addr` in 32: byte address (datapath ALU result).
- `wdata` in 32: store data.
- `sel` in 2: target select. 00 RAM, 01 external, 10 I/O, 11 invalid.
- `rdata` out 32: load data to the result mux.
- `busy` out 1: stall; the core must not advance PC while high.
- `ext_req` out 1: external request (registered).
- `ext_we`, `ext_addr[31:0]`, `ext_wdata[31:0]` out: external command, registered, stable while `ext_req`.
- `ext_rdata` in 32, `ext_ack` in 1: external response.
- `io_in` in 32: asynchronous switch/sensor input.
- `io_out` out 32: I/O output register.
- `err` out 1: sticky error flag.

## Operation
- States: IDLE, RAM_RD, EXT_WAIT, DONE.
- RAM word index = `addr[log2(DEPTH)+1:2]`. Upper bits are ignored, so out-of-range addresses wrap. `addr[1:0]` is ignored.
- IDLE, `req`, `sel`=00, `we`=1: RAM written at the edge; zero wait; stay in IDLE.
- IDLE, `req`, `sel`=00, `we`=0: go to RAM_RD. On the RAM_RD edge the read word is captured into `rdata_q`; go to DONE.
- IDLE, `req`, `sel`=01: latch the command into the `ext_*` registers, set `ext_req`, clear the watchdog, go to EXT_WAIT.
- EXT_WAIT:
  - On `ext_ack`: clear `ext_req`, capture `ext_rdata` into `rdata_q` (reads only), go to DONE.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1 without ack: clear `ext_req`, set `err`, set `rdata_q`=ERR_WORD, go to DONE.
- DONE: always returns to IDLE on the next edge, regardless of `req`.
- `sel`=10:
  - Write loads `io_out` at the edge; zero wait.
  - Read returns `io_sync`, a 2-flop synchroniser of `io_in`; zero wait.
- `sel`=11: no write, `rdata`=0, `err` set at the edge, zero wait.
- `err` stays set until reset.
- `req` low in IDLE: no state change.

## Timing
- Reset values: state IDLE, `busy` 0, `ext_req` 0, `ext_we` 0, `ext_addr`/`ext_wdata` 0, `rdata_q` 0, `io_out` 0, `io_sync` 0, `err` 0, watchdog 0.
- RAM contents are not cleared by reset.
- `busy` is combinational:
  - High in RAM_RD and in EXT_WAIT.
  - High in IDLE when `req` and (`sel`=01 or (`sel`=00 and !`we`)).
  - Low in DONE.
- `rdata`:
  - `rdata_q` in DONE.
  - `io_sync` in IDLE with `req`, `sel`=10, !`we`.
  - 0 otherwise.
- Latencies: RAM write 1 cycle. RAM read 3 cycles (IDLE, RAM_RD, DONE).
- External access: `ext_req` rises 1 cycle after the request. Completion is 1 cycle after the ack; if ack arrives on the first EXT_WAIT cycle, the access completes in DONE 2 cycles after IDLE.
- An `ext_ack` arriving in the same cycle the watchdog expires counts as success. `err` is not set.
- An `ext_ack` seen outside EXT_WAIT is ignored.
- `reset` asserted mid-access: immediate return to IDLE, `ext_req` drops asynchronously, and no partial write is committed.

## Test plan
- Reset, then RAM write 0x1234_5678 to addr 0x10, then read addr 0x10. Read: `busy` high for 2 cycles, `rdata`=0x1234_5678 in DONE.
- Write to addr 0x400 with DEPTH=256 (wraps to word 0), then read addr 0x0: `rdata` equals the written word.
- External read at addr 0x8000_0000 with ack after 3 cycles, `ext_rdata`=0xCAFE_F00D. `ext_req` is high exactly 3 cycles; `rdata`=0xCAFE_F00D; `err`=0.
- External write with ack held low: `ext_req` drops after TIMEOUT cycles, `err`=1, `rdata`=0xDEAD_BEEF, and the state returns to IDLE.
- I/O: write 0xA5 with `sel`=10, so `io_out`=0xA5 next cycle. Set `io_in`=0x3C; a read two or more cycles later returns 0x3C with `busy`=0.
- `sel`=11 access: `err` sets and stays set. Assert `reset` low during EXT_WAIT: `ext_req`=0 and `busy`=0 immediately, and all outputs return to their reset values.
